note_spawn_scheduler: RTL and testbench

//  Sequences the game's 7-bit LFSR to decide when and on which lanes new notes spawn.

---
 rtl/note_spawn_scheduler_pkg.sv | 28 ++
 rtl/note_lfsr.sv | 24 ++
 rtl/note_spawn_scheduler.sv | 159 +++++++++++++++
 tb/tb_note_spawn_scheduler.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/note_spawn_scheduler_pkg.sv
// Shared definitions for the note spawn scheduler: FSM encoding, widths and
// the difficulty-to-beat-interval table.
package note_spawn_scheduler_pkg;

    localparam int LFSR_W = 7;
    localparam int LANES  = 4;

    localparam logic [LFSR_W-1:0] DEF_SEED       = 7'h0F;
    localparam int                DEF_DRAW_STEPS = 7;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_DRAW  = 3'd2,
        ST_MAP   = 3'd3,
        ST_OFFER = 3'd4
    } state_t;

    // Beats between spawn draws; the two hardest levels both draw every beat.
    function automatic logic [2:0] beat_interval(input logic [1:0] difficulty);
        case (difficulty)
            2'd0:    return 3'd4;
            2'd1:    return 3'd2;
            default: return 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/note_lfsr.sv
// 7-bit Fibonacci LFSR (feedback bit6 ^ bit5) that advances only when asked.
// An all-zero state can never persist: it is reloaded with the seed.
module note_lfsr
    import note_spawn_scheduler_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = DEF_SEED
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              step,
    output logic [LFSR_W-1:0] rnd
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rnd <= SEED;
        end else if (rnd == '0) begin
            rnd <= SEED;
        end else if (step) begin
            rnd <= {rnd[LFSR_W-2:0], rnd[LFSR_W-1] ^ rnd[LFSR_W-2]};
        end
    end

endmodule

// File: rtl/note_spawn_scheduler.sv
// Counts beats, runs a 7-shift LFSR refresh per draw, maps the sample to a lane
// mask and offers it to the renderer.
// Handshake: a note transfers on a rising edge where note_valid & note_ready;
// note_valid and note_lanes hold steady until then, and note_lanes is 0 when idle.
module note_spawn_scheduler
    import note_spawn_scheduler_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED       = DEF_SEED,
    parameter int                DRAW_STEPS = DEF_DRAW_STEPS
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [1:0]       difficulty,
    input  logic             beat_tick,
    output logic             note_valid,
    input  logic             note_ready,
    output logic [LANES-1:0] note_lanes,
    output logic [7:0]       spawn_count,
    output logic             overrun,
    output state_t           fsm_state
);

    localparam logic [2:0] LAST_STEP = 3'(DRAW_STEPS - 1);

    state_t             state, state_n;
    logic [2:0]         beat_cnt, beat_n, step_cnt, step_n;
    logic [1:0]         diff_q, diff_n, lane_q, lane_n, prev_lane, prev_n;
    logic               valid_n, overrun_n, lfsr_step, enter_draw, resume;
    logic [LANES-1:0]   lanes_n, map_mask;
    logic [7:0]         count_n;
    logic [LFSR_W-1:0]  rnd;
    logic [2:0]         interval_live, interval_q, cnt_wait, cnt_sat;
    logic [1:0]         raw_lane, map_lane, chord_lane;
    logic               is_rest, is_chord;

    note_lfsr #(.SEED(SEED)) u_lfsr (
        .clock (clock),
        .reset (reset),
        .step  (lfsr_step),
        .rnd   (rnd)
    );

    assign fsm_state = state;

    // Beat counting and the lane mapping of the current LFSR sample.
    always_comb begin
        interval_live = beat_interval(difficulty);
        interval_q    = beat_interval(diff_q);
        cnt_wait      = beat_cnt + {2'b00, beat_tick};
        cnt_sat       = (beat_tick && (beat_cnt < interval_q)) ? beat_cnt + 3'd1 : beat_cnt;
        raw_lane      = rnd[1:0];
        is_rest       = (diff_q == 2'd0) && (rnd[5:4] == 2'b00);
        map_lane      = ((diff_q < 2'd2) && (raw_lane == prev_lane)) ? raw_lane + 2'd1 : raw_lane;
        is_chord      = (diff_q == 2'd3) && rnd[LFSR_W-1];
        chord_lane    = map_lane ^ (rnd[3:2] | 2'b01);
        map_mask      = (LANES'(1) << map_lane) | (is_chord ? (LANES'(1) << chord_lane) : '0);
    end

    always_comb begin
        state_n    = state;
        beat_n     = beat_cnt;
        step_n     = step_cnt;
        diff_n     = diff_q;
        lane_n     = lane_q;
        prev_n     = prev_lane;
        valid_n    = note_valid;
        lanes_n    = note_lanes;
        count_n    = spawn_count;
        overrun_n  = overrun;
        lfsr_step  = 1'b0;
        enter_draw = 1'b0;
        resume     = 1'b0;
        if (!enable) begin
            state_n = ST_IDLE;
            valid_n = 1'b0;
            lanes_n = '0;
            beat_n  = '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    state_n = ST_WAIT;
                    beat_n  = '0;
                end
                ST_WAIT: begin
                    if (cnt_wait >= interval_live) enter_draw = 1'b1;
                    else                           beat_n = cnt_wait;
                end
                ST_DRAW: begin
                    lfsr_step = 1'b1;
                    beat_n    = cnt_sat;
                    step_n    = step_cnt + 3'd1;
                    if (step_cnt == LAST_STEP) state_n = ST_MAP;
                end
                ST_MAP: begin
                    beat_n = cnt_sat;
                    if (is_rest) begin
                        resume = 1'b1;
                    end else begin
                        state_n = ST_OFFER;
                        valid_n = 1'b1;
                        lanes_n = map_mask;
                        lane_n  = map_lane;
                    end
                end
                ST_OFFER: begin
                    beat_n = cnt_sat;
                    if (beat_tick && (cnt_sat >= interval_q)) overrun_n = 1'b1;
                    if (note_ready) begin
                        valid_n = 1'b0;
                        lanes_n = '0;
                        count_n = spawn_count + 8'd1;
                        prev_n  = lane_q;
                        resume  = 1'b1;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
            // A full interval banked while busy starts the next draw without a WAIT cycle.
            if (resume) begin
                if (cnt_sat >= interval_q) enter_draw = 1'b1;
                else                       state_n = ST_WAIT;
            end
            if (enter_draw) begin
                state_n = ST_DRAW;
                beat_n  = '0;
                step_n  = '0;
                diff_n  = difficulty;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            beat_cnt    <= '0;
            step_cnt    <= '0;
            diff_q      <= '0;
            lane_q      <= '0;
            prev_lane   <= '0;
            note_valid  <= 1'b0;
            note_lanes  <= '0;
            spawn_count <= '0;
            overrun     <= 1'b0;
        end else begin
            state       <= state_n;
            beat_cnt    <= beat_n;
            step_cnt    <= step_n;
            diff_q      <= diff_n;
            lane_q      <= lane_n;
            prev_lane   <= prev_n;
            note_valid  <= valid_n;
            note_lanes  <= lanes_n;
            spawn_count <= count_n;
            overrun     <= overrun_n;
        end
    end

endmodule

// File: tb/tb_note_spawn_scheduler.sv
// Bench for note_spawn_scheduler: directed scenarios plus random beats/ready,
// with a draw-level model of the LFSR and lane rules feeding an expected queue.
module tb_note_spawn_scheduler;
    import note_spawn_scheduler_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic [1:0] difficulty = 2'd0;
    logic       beat_tick = 1'b0;
    logic       note_ready = 1'b0;
    logic       note_valid;
    logic [3:0] note_lanes;
    logic [7:0] spawn_count;
    logic       overrun;
    state_t     fsm_state;

    int errors = 0;
    int checks = 0;

    logic [3:0] exp_q[$];
    logic [1:0] exp_lane_q[$];
    logic [6:0] m_lfsr;
    logic [1:0] m_prev;
    logic [7:0] m_count;
    logic       last_rest;
    int cov_rest = 0;
    int cov_repeat = 0;
    int cov_chord = 0;
    int lat;

    note_spawn_scheduler dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .difficulty  (difficulty),
        .beat_tick   (beat_tick),
        .note_valid  (note_valid),
        .note_ready  (note_ready),
        .note_lanes  (note_lanes),
        .spawn_count (spawn_count),
        .overrun     (overrun),
        .fsm_state   (fsm_state)
    );

    // clock / reset
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // reference model
    function automatic logic [6:0] lfsr_next(input logic [6:0] r);
        return {r[5:0], r[6] ^ r[5]};
    endfunction

    task automatic model_reset();
        m_lfsr    = 7'h0F;
        m_prev    = 2'd0;
        m_count   = 8'd0;
        last_rest = 1'b0;
        exp_q.delete();
        exp_lane_q.delete();
    endtask

    task automatic model_draw(input logic [1:0] d, output logic rest,
                              output logic [3:0] mask, output logic [1:0] lane);
        int l;
        int other;
        for (int i = 0; i < 7; i++) m_lfsr = lfsr_next(m_lfsr);
        l    = int'(m_lfsr[1:0]);
        rest = (d == 2'd0) && (m_lfsr[5:4] == 2'b00);
        if (rest) cov_rest++;
        if (!rest && d < 2 && l == int'(m_prev)) begin
            l = (l + 1) % 4;
            cov_repeat++;
        end
        mask = 4'(1 << l);
        if (d == 2'd3 && m_lfsr[6]) begin
            other = l ^ (int'(m_lfsr[3:2]) | 1);
            mask  = mask | 4'(1 << other);
            cov_chord++;
        end
        lane = 2'(l);
    endtask

    // driver + scoreboard: one clock step, with all per-cycle checks after the edge
    task automatic step();
        logic       pre_acc, pre_disc, pre_en, was_rest, rest;
        logic [3:0] mask;
        logic [1:0] lane;
        pre_acc  = note_valid && note_ready && enable;
        pre_disc = note_valid && !enable;
        pre_en   = enable;
        was_rest = last_rest;
        @(posedge clock);
        #1;
        last_rest = 1'b0;
        if (!reset) return;
        if ((pre_acc || pre_disc) && exp_q.size() > 0) begin
            lane = exp_lane_q.pop_front();
            void'(exp_q.pop_front());
            if (pre_acc) begin
                m_count = m_count + 8'd1;
                m_prev  = lane;
            end
        end
        chk("spawn_count", spawn_count, m_count);
        if (!pre_en) chk("idle_after_disable", fsm_state, ST_IDLE);
        if (was_rest) chk("rest_no_offer", fsm_state == ST_OFFER, 1'b0);
        if (fsm_state == ST_MAP) begin
            model_draw(difficulty, rest, mask, lane);
            chk("lfsr_sample", dut.u_lfsr.rnd, m_lfsr);
            chk("lfsr_nonzero", dut.u_lfsr.rnd != 7'd0, 1'b1);
            if (rest) last_rest = 1'b1;
            else begin
                exp_q.push_back(mask);
                exp_lane_q.push_back(lane);
            end
        end
        if (note_valid) begin
            chk("unexpected_valid", exp_q.size() == 0, 1'b0);
            chk("note_lanes", note_lanes, (exp_q.size() > 0) ? exp_q[0] : 4'h0);
        end else begin
            chk("lanes_zero_when_idle", note_lanes, 4'h0);
        end
    endtask

    task automatic pulse_tick();
        beat_tick = 1'b1;
        step();
        beat_tick = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int i = 0;
        while (!note_valid && i < budget) begin
            step();
            i++;
        end
        chk(tag, note_valid, 1'b1);
    endtask

    task automatic settle();
        int i = 0;
        beat_tick  = 1'b0;
        note_ready = 1'b1;
        while (!(fsm_state == ST_WAIT && !note_valid) && i < 40) begin
            step();
            i++;
        end
        chk("settle_wait", fsm_state, ST_WAIT);
    endtask

    task automatic run_random(input int n);
        for (int i = 0; i < n; i++) begin
            beat_tick  = !beat_tick && ($urandom_range(0, 2) == 0);
            note_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        beat_tick = 1'b0;
    endtask

    initial begin
        model_reset();
        // 1: reset values, first draw from the seed, latency and lane mapping
        repeat (2) @(posedge clock);
        #1;
        chk("rst_valid", note_valid, 1'b0);
        chk("rst_lanes", note_lanes, 4'h0);
        chk("rst_count", spawn_count, 8'd0);
        chk("rst_overrun", overrun, 1'b0);
        chk("rst_state", fsm_state, ST_IDLE);
        chk("rst_lfsr", dut.u_lfsr.rnd, 7'h0F);
        reset      = 1'b1;
        enable     = 1'b1;
        difficulty = 2'd0;
        note_ready = 1'b1;
        step();
        chk("wait_after_enable", fsm_state, ST_WAIT);
        repeat (3) begin
            pulse_tick();
            step();
        end
        pulse_tick();
        lat = 1;
        while (!note_valid && lat < 30) begin
            step();
            lat++;
        end
        chk("t1_latency", lat, 9);
        chk("t1_lanes", note_lanes, 4'b0010);
        step();
        chk("t1_count", spawn_count, 8'd1);

        // 2: renderer stalls for 20 cycles
        note_ready = 1'b0;
        repeat (4) begin
            pulse_tick();
            step();
        end
        wait_valid("t2_valid_seen", 40);
        for (int i = 0; i < 20; i++) begin
            step();
            chk("t2_hold_valid", note_valid, 1'b1);
            chk("t2_hold_lanes", note_lanes, 4'b1000);
            chk("t2_hold_count", spawn_count, 8'd1);
        end
        note_ready = 1'b1;
        step();
        chk("t2_count_after", spawn_count, 8'd2);
        chk("t2_valid_after", note_valid, 1'b0);

        // 3: interval elapses during a pending offer
        difficulty = 2'd2;
        note_ready = 1'b0;
        pulse_tick();
        wait_valid("t3_valid_seen", 30);
        chk("t3_overrun_before", overrun, 1'b0);
        pulse_tick();
        step();
        pulse_tick();
        step();
        chk("t3_overrun", overrun, 1'b1);
        note_ready = 1'b1;
        step();
        chk("t3_immediate_draw", fsm_state, ST_DRAW);
        repeat (20) step();

        // 4/5: random beats and back-pressure at every difficulty
        for (int d = 0; d < 4; d++) begin
            settle();
            difficulty = 2'(d);
            run_random(400);
        end
        settle();
        difficulty = 2'd0;
        run_random(300);

        // 6: reset while offering, then enable dropped mid-draw
        settle();
        difficulty = 2'd2;
        note_ready = 1'b0;
        pulse_tick();
        wait_valid("t6_valid_seen", 30);
        reset = 1'b0;
        #1;
        chk("t6_async_valid", note_valid, 1'b0);
        chk("t6_async_lanes", note_lanes, 4'h0);
        chk("t6_async_count", spawn_count, 8'd0);
        chk("t6_async_state", fsm_state, ST_IDLE);
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        reset      = 1'b1;
        note_ready = 1'b1;
        step();
        pulse_tick();
        chk("t6_in_draw", fsm_state, ST_DRAW);
        repeat (3) step();
        enable = 1'b0;
        step();
        for (int i = 0; i < 3; i++) m_lfsr = lfsr_next(m_lfsr);
        chk("t6_disable_state", fsm_state, ST_IDLE);
        chk("t6_disable_valid", note_valid, 1'b0);
        repeat (3) step();
        chk("t6_lfsr_kept", dut.u_lfsr.rnd, m_lfsr);
        enable = 1'b1;
        step();
        pulse_tick();
        lat = 0;
        while (spawn_count == 8'd0 && lat < 30) begin
            step();
            lat++;
        end
        chk("t6_resume_count", spawn_count, 8'd1);

        // report
        chk("cov_rest_seen", cov_rest > 0, 1'b1);
        chk("cov_repeat_seen", cov_repeat > 0, 1'b1);
        chk("cov_chord_seen", cov_chord > 0, 1'b1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
